// File: rtl/ag_o_gen.sv
// ag_o_gen: output-address generator for the sys_out DPR with lane masks, row/column-major order and valid/ready backpressure
module ag_o_gen #(
  parameter int FEATURE_BITS = 4,
  parameter int ADDR_W = 2 * FEATURE_BITS,
  parameter int P = 4
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [FEATURE_BITS-1:0] m_cfg,
  input  logic [FEATURE_BITS-1:0] n_cfg,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic                    col_major,
  output logic [ADDR_W-1:0]       address,
  output logic [P-1:0]            lane_mask,
  output logic                    addr_valid,
  input  logic                    addr_ready,
  output logic                    busy,
  output logic                    done
);
  localparam int LOG2P = $clog2(P);
  localparam logic [FEATURE_BITS:0] RND = FEATURE_BITS'(P - 1);
  localparam logic [FEATURE_BITS-1:0] REM_MSK = FEATURE_BITS'(P - 1);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state;
  logic [FEATURE_BITS-1:0] m_r, wpr_r, r_idx, w_idx, nr, nw, wpr_c, rem_c;
  logic [FEATURE_BITS:0] n_round;
  logic [ADDR_W-1:0] base_r;
  logic col_r, last_w, last_r, hs;
  logic [P-1:0] last_mask_r, last_mask_c;
  always_comb begin
    n_round = {1'b0, n_cfg} + RND;
    wpr_c = FEATURE_BITS'(n_round >> LOG2P);
    rem_c = n_cfg & REM_MSK;
    last_mask_c = (rem_c == '0) ? '1 : ~({P{1'b1}} << rem_c);
    last_w = w_idx == wpr_r - 1'b1;
    last_r = r_idx == m_r - 1'b1;
    hs = addr_valid && addr_ready;
    nr = col_r ? (last_r ? '0 : r_idx + 1'b1) : (last_w ? r_idx + 1'b1 : r_idx);
    nw = col_r ? (last_r ? w_idx + 1'b1 : w_idx) : (last_w ? '0 : w_idx + 1'b1);
  end
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state <= IDLE;
      m_r <= '0;
      wpr_r <= '0;
      last_mask_r <= '0;
      base_r <= '0;
      col_r <= 1'b0;
      r_idx <= '0;
      w_idx <= '0;
      address <= '0;
      lane_mask <= '0;
      addr_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          m_r <= m_cfg;
          wpr_r <= wpr_c;
          last_mask_r <= last_mask_c;
          base_r <= base_addr;
          col_r <= col_major;
          r_idx <= '0;
          w_idx <= '0;
          busy <= 1'b1;
          if (m_cfg == '0 || n_cfg == '0) begin
            state <= FIN;
            done <= 1'b1;
          end else begin
            state <= RUN;
            addr_valid <= 1'b1;
            address <= base_addr;
            lane_mask <= (wpr_c == FEATURE_BITS'(1)) ? last_mask_c : '1;
          end
        end
        RUN: if (hs) begin
          if (last_w && last_r) begin
            state <= FIN;
            addr_valid <= 1'b0;
            done <= 1'b1;
          end else begin
            r_idx <= nr;
            w_idx <= nw;
            address <= base_r + ADDR_W'(nr) * ADDR_W'(wpr_r) + ADDR_W'(nw);
            lane_mask <= (nw == wpr_r - 1'b1) ? last_mask_r : '1;
          end
        end
        FIN: begin
          state <= IDLE;
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
